// File: rtl/life_seq_ctrl.sv
// life_seq_ctrl: sequencing controller for the 8x8 life array.
// Loads a 64-bit seed into the array's four 4x4 tiles. Generates the array's
// step strobe, either free-running at a programmable period or one step per
// single_step rising edge. Keeps a generation counter for status display.
module life_seq_ctrl #(
  parameter int PERIOD_W = 16,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_req,
  input  logic [63:0]         load_pattern,
  input  logic                run,
  input  logic                single_step,
  input  logic [PERIOD_W-1:0] period,
  output logic [15:0]         vali,
  output logic [1:0]          vali_selector,
  output logic                write_enb,
  output logic                step,
  output logic                busy,
  output logic                load_done,
  output logic [GEN_W-1:0]    gen_count
);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;

  state_e              state_q;
  logic [63:0]         pat_q;
  logic [PERIOD_W-1:0] tick_q;
  logic                ss_q;

  // A period of 0 behaves as 1, so stepping never stalls.
  logic [PERIOD_W-1:0] p_eff;
  assign p_eff = (period == '0) ? PERIOD_W'(1) : period;

  // Tile index presented on the next write cycle of a load.
  logic [1:0] nsel;
  assign nsel = vali_selector + 2'd1;

  // Controller FSM. Every output is a register driven from here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      tick_q        <= '0;
      ss_q          <= 1'b0;
      vali          <= '0;
      vali_selector <= '0;
      write_enb     <= 1'b0;
      step          <= 1'b0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      gen_count     <= '0;
    end else begin
      // single_step history is kept in every state so a level held
      // across a load cannot look like a fresh edge afterwards.
      ss_q      <= single_step;
      load_done <= 1'b0;
      step      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_req) begin
            // Load wins over run and single_step; a step due now is dropped.
            state_q       <= LOAD;
            pat_q         <= load_pattern;
            busy          <= 1'b1;
            write_enb     <= 1'b1;
            vali_selector <= 2'd0;
            vali          <= load_pattern[15:0];
            tick_q        <= '0;
            gen_count     <= '0;
          end else if (run) begin
            // >= rather than == so shrinking the period mid-count fires now.
            if (tick_q >= p_eff - PERIOD_W'(1)) begin
              tick_q    <= '0;
              step      <= 1'b1;
              gen_count <= gen_count + GEN_W'(1);
            end else begin
              tick_q <= tick_q + PERIOD_W'(1);
            end
          end else begin
            tick_q <= '0;
            if (single_step && !ss_q) begin
              step      <= 1'b1;
              gen_count <= gen_count + GEN_W'(1);
            end
          end
        end
        LOAD: begin
          // One tile per cycle; the last tile's cycle ends the load.
          if (vali_selector == 2'd3) begin
            state_q       <= IDLE;
            write_enb     <= 1'b0;
            busy          <= 1'b0;
            load_done     <= 1'b1;
            vali          <= '0;
            vali_selector <= '0;
          end else begin
            vali_selector <= nsel;
            vali          <= pat_q[{nsel, 4'b0000} +: 16];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_seq_ctrl.sv
// Bench for life_seq_ctrl: a transaction-level model predicts the outputs
// every cycle, and directed scenarios pin the model with literal values.
module tb_life_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic [63:0] load_pattern = '0;
  logic        run = 1'b0;
  logic        single_step = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] vali;
  logic [1:0]  vali_selector;
  logic        write_enb, step, busy, load_done;
  logic [15:0] gen_count;

  life_seq_ctrl #(.PERIOD_W(16), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_pattern(load_pattern),
    .run(run), .single_step(single_step), .period(period),
    .vali(vali), .vali_selector(vali_selector), .write_enb(write_enb),
    .step(step), .busy(busy), .load_done(load_done), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // ---------------- model ----------------
  // Pending tile writes as a queue; front entry is what the array sees now.
  logic [17:0] wq[$];
  int          m_since = 0;   // cycles elapsed since last run-mode step
  int          m_gen = 0;
  logic        m_prev = 1'b0;
  logic [15:0] e_vali = '0;
  logic [1:0]  e_sel = '0;
  logic        e_we = 0, e_step = 0, e_busy = 0, e_done = 0;

  always @(posedge clk or negedge reset) begin
    int   p;
    logic prev;
    if (!reset) begin
      wq.delete();
      m_since = 0; m_gen = 0; m_prev = 0;
      e_vali = 0; e_sel = 0; e_we = 0; e_step = 0; e_busy = 0; e_done = 0;
    end else begin
      prev   = m_prev;
      m_prev = single_step;
      e_done = 0;
      e_step = 0;
      if (wq.size() > 0) begin
        void'(wq.pop_front());
        if (wq.size() == 0) begin
          e_done = 1; e_busy = 0; e_we = 0; e_vali = 0; e_sel = 0;
        end else begin
          {e_sel, e_vali} = wq[0];
        end
      end else if (load_req) begin
        for (int k = 0; k < 4; k++) wq.push_back({k[1:0], load_pattern[16*k +: 16]});
        {e_sel, e_vali} = wq[0];
        e_we = 1; e_busy = 1; m_since = 0; m_gen = 0;
      end else if (run) begin
        p = (period == 0) ? 1 : int'(period);
        m_since = m_since + 1;
        if (m_since >= p) begin
          m_since = 0; e_step = 1; m_gen = (m_gen + 1) % 65536;
        end
      end else begin
        m_since = 0;
        if (single_step && !prev) begin
          e_step = 1; m_gen = (m_gen + 1) % 65536;
        end
      end
    end
  end

  // ---------------- per-cycle compare + observation ----------------
  logic [17:0] wr_log[$];
  int steps_seen = 0, busy_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    total++;
    if ({vali, vali_selector, write_enb, step, busy, load_done, gen_count} !==
        {e_vali, e_sel, e_we, e_step, e_busy, e_done, 16'(m_gen)}) begin
      bad++;
      $display("FAIL cycle t=%0t got vali=%h sel=%0d we=%b step=%b busy=%b done=%b gen=%h exp vali=%h sel=%0d we=%b step=%b busy=%b done=%b gen=%h",
               $time, vali, vali_selector, write_enb, step, busy, load_done, gen_count,
               e_vali, e_sel, e_we, e_step, e_busy, e_done, 16'(m_gen));
    end
    total++;
    if (write_enb && step) begin
      bad++;
      $display("FAIL we_step_overlap t=%0t got both high required not both", $time);
    end
    if (write_enb) wr_log.push_back({vali_selector, vali});
    if (step) steps_seen++;
    if (busy) busy_cnt++;
    if (load_done) done_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Advance n clocks; inputs are then driven / outputs read mid-low-phase.
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr_obs();
    wr_log.delete();
    steps_seen = 0; busy_cnt = 0; done_cnt = 0;
  endtask

  task automatic do_load(input logic [63:0] pat);
    load_pattern = pat; load_req = 1;
    tick_n(1);
    load_req = 0;
    tick_n(5);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    tick_n(2);
    chk("reset_outputs", {vali, vali_selector, write_enb, step, busy, load_done, gen_count}, '0);
    reset = 1;
    tick_n(1);

    // Seed load; pattern changes during LOAD must not leak into the writes.
    clr_obs();
    load_pattern = 64'h0000_0380_0000_0007; load_req = 1;
    tick_n(1);
    load_req = 0; load_pattern = 64'hFFFF_FFFF_FFFF_FFFF;
    tick_n(5);
    chk("load_nwr", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("load_wr0", wr_log[0], {2'd0, 16'h0007});
      chk("load_wr1", wr_log[1], {2'd1, 16'h0000});
      chk("load_wr2", wr_log[2], {2'd2, 16'h0380});
      chk("load_wr3", wr_log[3], {2'd3, 16'h0000});
    end
    chk("load_busy_cycles", busy_cnt, 4);
    chk("load_done_pulses", done_cnt, 1);
    chk("load_gen", gen_count, 0);

    // Run mode, period 4, then period 0 means every cycle.
    clr_obs();
    period = 4; run = 1;
    tick_n(3);
    chk("run_no_step_early", steps_seen, 0);
    tick_n(1);
    chk("run_step_4th", step, 1);
    tick_n(16);
    chk("run_p4_steps", steps_seen, 5);
    chk("run_p4_gen", gen_count, 5);
    clr_obs();
    period = 0;
    tick_n(5);
    chk("run_p0_steps", steps_seen, 5);
    chk("run_p0_gen", gen_count, 10);

    // Single-step edges; a level held through a load does not step.
    run = 0; single_step = 1;
    do_load(64'h0123_4567_89AB_CDEF);
    clr_obs();
    tick_n(3);
    chk("ss_held_thru_load", steps_seen, 0);
    tick_n(7);
    single_step = 0; tick_n(3);
    single_step = 1; tick_n(3);
    single_step = 0; tick_n(2);
    chk("ss_steps", steps_seen, 1);
    chk("ss_gen", gen_count, 1);
    single_step = 1; tick_n(10);
    single_step = 0; tick_n(2);
    single_step = 1; tick_n(2);
    single_step = 0; tick_n(2);
    chk("ss_steps2", steps_seen, 3);
    chk("ss_gen2", gen_count, 3);
    clr_obs();
    run = 1; period = 100; tick_n(1);
    single_step = 1; tick_n(1);
    single_step = 0; tick_n(3);
    chk("ss_ignored_in_run", steps_seen, 0);
    run = 0; tick_n(2);

    // Load arriving exactly when a run step is due.
    clr_obs();
    run = 1; period = 3;
    tick_n(2);
    load_pattern = 64'hAAAA_BBBB_CCCC_DDDD; load_req = 1;
    tick_n(1);
    load_req = 0;
    chk("collide_step_suppressed", step, 0);
    chk("collide_busy", busy, 1);
    tick_n(4);
    chk("collide_done", load_done, 1);
    tick_n(2);
    chk("collide_no_steps", steps_seen, 0);
    chk("collide_gen0", gen_count, 0);
    tick_n(1);
    chk("collide_resume_step", step, 1);
    chk("collide_resume_gen", gen_count, 1);
    run = 0; tick_n(2);

    // Reset in the second write cycle of a load.
    clr_obs();
    load_pattern = 64'h5555_6666_7777_8888; load_req = 1;
    tick_n(1);
    load_req = 0;
    tick_n(1);
    chk("midload_sel1", vali_selector, 1);
    reset = 0; #1;
    chk("midload_async_zero", {vali, vali_selector, write_enb, step, busy, load_done, gen_count}, '0);
    tick_n(1);
    reset = 1;
    tick_n(6);
    chk("midload_no_done", done_cnt, 0);
    clr_obs();
    do_load(64'h1234_5678_9ABC_DEF0);
    chk("reload_done", done_cnt, 1);
    chk("reload_nwr", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("reload_wr0", wr_log[0], {2'd0, 16'hDEF0});
      chk("reload_wr3", wr_log[3], {2'd3, 16'h1234});
    end

    // Generation counter wrap.
    run = 1; period = 1;
    tick_n(65534);
    chk("wrap_pre", gen_count, 16'hFFFE);
    tick_n(1);
    chk("wrap_ffff", gen_count, 16'hFFFF);
    tick_n(1);
    chk("wrap_0000", gen_count, 16'h0000);
    tick_n(1);
    chk("wrap_0001", gen_count, 16'h0001);
    run = 0;
    tick_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_seq_ctrl.md
Name: life_seq_ctrl

Overview:
Sequencing controller directly upstream of the 8x8 life array. Loads a 64-bit seed pattern into the array's four 4x4 tiles through the array's vali/vali_selector/write_enb port. Generates the array's one-cycle step pulse, either free-running at a programmable period or as single steps. Keeps a generation counter for status display.

Parameters:
PERIOD_W, 16, width of period input and internal tick counter
GEN_W, 16, width of generation counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
load_req  input  1  level; sampled each edge; starts pattern load
load_pattern  input  64  seed; tile k = bits [16k+15:16k], k=0..3
run  input  1  level; 1 = free-running stepping
single_step  input  1  request one generation; rising-edge detected
period  input  PERIOD_W  cycles between steps in run mode; 0 treated as 1
vali  output  16  tile data to array
vali_selector  output  2  tile index to array
write_enb  output  1  tile write strobe to array
step  output  1  one-cycle generation strobe to array
busy  output  1  high while in LOAD
load_done  output  1  one-cycle pulse when load completes
gen_count  output  GEN_W  generations stepped since last load

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; vali=0, vali_selector=0, write_enb=0, step=0, busy=0, load_done=0, gen_count=0; tick counter=0; pattern register=0; single_step edge register=0.
- All outputs are registered.
- FSM states: IDLE, LOAD.
- IDLE, load_req=1 at edge N:
  - latch load_pattern; go to LOAD; busy=1 from cycle N+1.
  - Tick counter cleared; gen_count cleared to 0.
  - Any step that would have fired at this edge is suppressed. Load has priority over run and single_step.
- LOAD:
  - Cycles N+1..N+4: write_enb=1, vali_selector=0,1,2,3, vali = latched slice for that selector.
  - At the edge ending cycle N+4: return to IDLE, write_enb=0, busy=0, load_done=1 for cycle N+5 only.
  - load_req, run and single_step are ignored in LOAD. step is held at 0.
  - A load_pattern change during LOAD has no effect.
- Run mode (IDLE, run=1, no load_req):
  - Effective period P = max(period,1).
  - Each edge: if tick >= P-1, then tick<=0, step<=1, gen_count<=gen_count+1; else tick<=tick+1, step<=0.
  - First step is high in the P-th cycle after run is first sampled high. P=1 gives step every cycle.
  - Comparison is >=, so lowering period mid-count fires on the next edge.
- run=0 (IDLE): tick<=0.
  - Rising edge of single_step (registered previous value 0, current 1) gives step=1 for exactly one cycle and gen_count+1.
  - Holding single_step high gives only one step.
  - single_step is ignored when run=1.
- After load completes, the previous single_step value is still tracked, so a level held through LOAD does not trigger a step.
- gen_count wraps 2^GEN_W-1 → 0.
- write_enb and step are never high in the same cycle.
- Reset asserted mid-LOAD: writes stop immediately, load_done is not pulsed, IDLE on release.

Test Plan:
- Reset, then load_req=1 for one cycle with load_pattern=64'h0000_0380_0000_0007 → four consecutive write_enb cycles with (sel,vali) = (0,0007),(1,0000),(2,0380),(3,0000); load_done pulses one cycle later; busy high exactly 4 cycles; gen_count=0.
- run=1, period=4 for 20 cycles → step high on cycles 4,8,12,16,20 after run rises; gen_count=5. Then period=0 → step every cycle.
- run=0, single_step held high 10 cycles, then low, then high again → exactly two step pulses, gen_count=2. single_step pulsed with run=1, period=100 → no extra step.
- run=1, period=3, load_req asserted on the cycle a step is due → no step that cycle, no step during the 4 write cycles, gen_count=0, stepping resumes 3 cycles after load completes.
- Reset pulsed low during the second write cycle of a load → all outputs 0 asynchronously, no load_done; a new load after release completes normally.
- Force gen_count to 16'hFFFE, run with period=1 for 3 cycles → gen_count sequence FFFF, 0000, 0001.
